// File: rtl/mem_stage.sv
// MEM pipeline stage: tracks the single outstanding data-SRAM response, aligns and
// extends load data, and forwards exception/CSR fields to WB.
module mem_stage #(
    parameter int ES_TO_MS_WD = 173,
    parameter int MS_TO_WS_WD = 169
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic                   ms_allowin,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    input  logic                   excp_flush,
    input  logic                   ertn_flush,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    output logic [38:0]            ms_forward,
    output logic                   ms_load_pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ms_valid;
    logic [ES_TO_MS_WD-1:0] bus_r;
    logic                   rdata_buf_valid;
    logic [31:0]            rdata_buf;

    logic        flush;
    logic        es_accept;
    logic        es_req_issued;
    logic        ms_ready_go;
    logic [31:0] pc_r;
    logic [31:0] alu_result;
    logic        gr_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [2:0]  mem_op;
    logic        req_issued_r;
    logic [31:0] mem_src;
    logic [31:0] mem_shifted;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign pc_r         = bus_r[172:141];
    assign dest         = bus_r[139:135];
    assign gr_we        = bus_r[134];
    assign alu_result   = bus_r[132:101];
    assign res_from_mem = bus_r[4];
    assign mem_op       = bus_r[3:1];
    assign req_issued_r = bus_r[0];

    assign flush         = excp_flush | ertn_flush;
    assign es_req_issued = es_to_ms_bus[0];

    assign ms_ready_go    = !(req_issued_r && (state == S_WAIT) && !data_sram_data_ok);
    // A stale response owed in DROP must retire before a new request may enter.
    assign ms_allowin     = (!ms_valid || (ms_ready_go && ws_allowin))
                          && ((state != S_DROP) || data_sram_data_ok)
                          && !flush;
    assign es_accept      = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (es_accept && es_req_issued) state_nxt = S_WAIT;
            S_WAIT: begin
                if (data_sram_data_ok)
                    state_nxt = (es_accept && es_req_issued) ? S_WAIT : S_IDLE;
                else if (flush)
                    state_nxt = S_DROP;
            end
            S_DROP: begin
                if (data_sram_data_ok)
                    state_nxt = (es_accept && es_req_issued) ? S_WAIT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            ms_valid        <= 1'b0;
            rdata_buf_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (flush)
                rdata_buf_valid <= 1'b0;
            else if (ms_to_ws_valid && ws_allowin)
                rdata_buf_valid <= 1'b0;
            else if (ms_valid && (state == S_WAIT) && data_sram_data_ok)
                rdata_buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (es_accept)
            bus_r <= es_to_ms_bus;
        if (ms_valid && (state == S_WAIT) && data_sram_data_ok && !flush && !ws_allowin)
            rdata_buf <= data_sram_rdata;
    end

    assign mem_src     = rdata_buf_valid ? rdata_buf : data_sram_rdata;
    assign mem_shifted = mem_src >> {alu_result[1:0], 3'b000};

    always_comb begin
        load_result = mem_shifted;
        case (mem_op[1:0])
            2'b00:   load_result = {{24{mem_op[2] & mem_shifted[7]}},  mem_shifted[7:0]};
            2'b01:   load_result = {{16{mem_op[2] & mem_shifted[15]}}, mem_shifted[15:0]};
            default: load_result = mem_shifted;
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    // Top bit is spare; fields from pc down to csr_wdata occupy [167:0].
    assign ms_to_ws_bus    = {1'b0, pc_r, bus_r[140:133], final_result, bus_r[100:5]};
    assign ms_forward      = {ms_valid, gr_we, dest, final_result};
    assign ms_load_pending = ms_valid && res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load alignment, WB backpressure,
// flush drain, excepted ops and mid-wait reset.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         es_to_ms_valid;
    logic [172:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [168:0] ms_to_ws_bus;
    logic         excp_flush;
    logic         ertn_flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [38:0]  ms_forward;
    logic         ms_load_pending;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage #(.ES_TO_MS_WD(173), .MS_TO_WS_WD(169)) dut (
        .clk              (clk),
        .reset            (reset),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .ms_allowin       (ms_allowin),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .excp_flush       (excp_flush),
        .ertn_flush       (ertn_flush),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .ms_forward       (ms_forward),
        .ms_load_pending  (ms_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [172:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                        input logic rfm, input logic [2:0] op,
                                        input logic req, input logic excp,
                                        input logic [15:0] en);
        return {pc, 1'b0, 5'd7, 1'b1, 1'b0, alu, excp, en, 1'b0, 14'h0, 32'h0,
                32'h5A5A0000, rfm, op, req};
    endfunction

    function automatic logic [31:0] wb_result(input logic [168:0] b);
        return b[127:96];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        step(); step();
        mid();
        check("rst_valid",   {31'b0, ms_to_ws_valid},  32'd0);
        check("rst_fwd",     {31'b0, ms_forward[38]},  32'd0);
        check("rst_pending", {31'b0, ms_load_pending}, 32'd0);
        check("rst_allowin", {31'b0, ms_allowin},      32'd1);
        step();
        reset = 1'b1;

        // 1: lw 0x1000, response two cycles after issue
        step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0100, 32'h0000_1000, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid = 1'b0;
        mid();
        check("t1_wait_valid", {31'b0, ms_to_ws_valid},  32'd0);
        check("t1_pending",    {31'b0, ms_load_pending}, 32'd1);
        check("t1_fwd_valid",  {31'b0, ms_forward[38]},  32'd1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        mid();
        check("t1_valid",   {31'b0, ms_to_ws_valid},   32'd1);
        check("t1_result",  wb_result(ms_to_ws_bus),   32'hDEAD_BEEF);
        check("t1_pc",      ms_to_ws_bus[167:136],     32'h1C00_0100);
        check("t1_fwd_res", ms_forward[31:0],          32'hDEAD_BEEF);
        check("t1_nopend",  {31'b0, ms_load_pending},  32'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        mid();
        check("t1_gone", {31'b0, ms_to_ws_valid}, 32'd0);

        // 2: lb / lbu at offset 3
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0104, 32'h0000_2003, 1'b1, 3'b100, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        mid();
        check("t2_lb", wb_result(ms_to_ws_bus), 32'hFFFF_FF80);
        step();
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(32'h1C00_0108, 32'h0000_2003, 1'b1, 3'b000, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        mid();
        check("t2_lbu", wb_result(ms_to_ws_bus), 32'h0000_0080);
        step();
        data_sram_data_ok = 1'b0;

        // 3: lh at offset 2 with WB stalled around the response
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_010C, 32'h0000_3002, 1'b1, 3'b101, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        mid();
        check("t3_dok_res", wb_result(ms_to_ws_bus), 32'h0000_1234);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hFFFF_FFFF;
        mid();
        check("t3_held_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        check("t3_held_res",   wb_result(ms_to_ws_bus), 32'h0000_1234);
        check("t3_allowin",    {31'b0, ms_allowin},     32'd0);
        check("t3_nopend",     {31'b0, ms_load_pending}, 32'd0);
        step();
        mid();
        check("t3_held2_res", wb_result(ms_to_ws_bus), 32'h0000_1234);
        step();
        ws_allowin = 1'b1;
        mid();
        check("t3_hand_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        check("t3_hand_res",   wb_result(ms_to_ws_bus), 32'h0000_1234);
        step();
        mid();
        check("t3_once", {31'b0, ms_to_ws_valid}, 32'd0);

        // 4: flush during WAIT, stale response three cycles later
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0110, 32'h0000_4000, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid = 1'b0;
        excp_flush     = 1'b1;
        mid();
        check("t4_flush_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        check("t4_flush_allow", {31'b0, ms_allowin},     32'd0);
        step();
        excp_flush     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0114, 32'h0000_5000, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0);
        mid();
        check("t4_drop_allow1", {31'b0, ms_allowin},     32'd0);
        check("t4_drop_valid",  {31'b0, ms_to_ws_valid}, 32'd0);
        step();
        mid();
        check("t4_drop_allow2", {31'b0, ms_allowin}, 32'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        mid();
        check("t4_stale_allow", {31'b0, ms_allowin},     32'd1);
        check("t4_stale_valid", {31'b0, ms_to_ws_valid}, 32'd0);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        mid();
        check("t4_new_pending", {31'b0, ms_load_pending}, 32'd1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_CAFE;
        mid();
        check("t4_new_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        check("t4_new_res",   wb_result(ms_to_ws_bus), 32'h0000_CAFE);
        check("t4_new_pc",    ms_to_ws_bus[167:136],   32'h1C00_0114);
        step();
        data_sram_data_ok = 1'b0;

        // 5: excepted load that never issued a request
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0118, 32'h0000_6001, 1'b1, 3'b010, 1'b0, 1'b1, 16'h0040);
        step();
        es_to_ms_valid = 1'b0;
        mid();
        check("t5_valid",    {31'b0, ms_to_ws_valid},        32'd1);
        check("t5_pending",  {31'b0, ms_load_pending},       32'd0);
        check("t5_excp",     {31'b0, ms_to_ws_bus[95]},      32'd1);
        check("t5_excp_num", {16'b0, ms_to_ws_bus[94:79]},   32'h0000_0040);
        check("t5_wdata",    ms_to_ws_bus[31:0],             32'h5A5A_0000);
        step();
        mid();
        check("t5_gone", {31'b0, ms_to_ws_valid}, 32'd0);

        // store: waits for data_ok, result is the address, never load-pending
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_011C, 32'h0000_7004, 1'b0, 3'b010, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid = 1'b0;
        mid();
        check("st_wait_valid", {31'b0, ms_to_ws_valid},  32'd0);
        check("st_nopend",     {31'b0, ms_load_pending}, 32'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        mid();
        check("st_res", wb_result(ms_to_ws_bus), 32'h0000_7004);
        step();
        data_sram_data_ok = 1'b0;

        // 6: reset asserted while waiting
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0120, 32'h0000_8000, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid = 1'b0;
        #2;
        reset = 1'b0;
        mid();
        check("t6_rst_valid",   {31'b0, ms_to_ws_valid},  32'd0);
        check("t6_rst_fwd",     {31'b0, ms_forward[38]},  32'd0);
        check("t6_rst_pending", {31'b0, ms_load_pending}, 32'd0);
        step();
        reset = 1'b1;
        mid();
        check("t6_allow", {31'b0, ms_allowin}, 32'd1);
        step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1C00_0124, 32'h0000_9001, 1'b1, 3'b001, 1'b1, 1'b0, 16'h0);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00AB_CD00;
        mid();
        check("t6_valid", {31'b0, ms_to_ws_valid}, 32'd1);
        check("t6_lhu",   wb_result(ms_to_ws_bus), 32'h0000_ABCD);
        step();
        data_sram_data_ok = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
